palette_ram_v2: RTL

Parametrised colour palette for the video output path. Holds separate red, green and blue lookup tables indexed by an INDEX_BITS pixel code. Each pixel is selected from one of two layer indices, looked up through a two-stage pipeline gated by the pixel clock enable, and forced to black outside the active display. The block adds three things: a CPU port with a read-data valid strobe, a hardware clear sequencer, and configurable colour and index widths.

---
 rtl/palette_ram_v2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/palette_ram_v2.sv
// Colour palette: R/G/B lookup tables with a two-stage video pipeline,
// a CPU read/write port and a hardware clear sequencer.
module palette_ram_v2 #(
  parameter int unsigned COLOR_BITS     = 5,
  parameter int unsigned INDEX_BITS     = 8,
  parameter int unsigned CLEAR_VALUE    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic                  dclk,
  input  logic                  reset,
  input  logic                  ce_pix,
  input  logic [INDEX_BITS-1:0] ca,
  input  logic [INDEX_BITS-1:0] cb,
  input  logic                  sel,
  input  logic                  de,
  input  logic [INDEX_BITS+1:0] cpu_addr,
  input  logic [COLOR_BITS-1:0] cpu_din,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  output logic [COLOR_BITS-1:0] cpu_dout,
  output logic                  cpu_rd_valid,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [COLOR_BITS-1:0] r_out,
  output logic [COLOR_BITS-1:0] g_out,
  output logic [COLOR_BITS-1:0] b_out,
  output logic                  de_out
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [1:0] CH_R = 2'b00;
  localparam logic [1:0] CH_G = 2'b01;
  localparam logic [1:0] CH_B = 2'b10;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = {INDEX_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] CLR_DATA = COLOR_BITS'(CLEAR_VALUE);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Storage: one video read port and one CPU/clear port per channel
  logic [COLOR_BITS-1:0] mem_r [DEPTH];
  logic [COLOR_BITS-1:0] mem_g [DEPTH];
  logic [COLOR_BITS-1:0] mem_b [DEPTH];

  state_t                state, state_next;
  logic [INDEX_BITS-1:0] cnt, cnt_next;
  logic                  start_pending;
  logic                  busy_q;

  logic [1:0]            cpu_ch;
  logic [INDEX_BITS-1:0] cpu_idx;
  logic                  clr_we;
  logic                  cpu_we;
  logic                  we_r, we_g, we_b;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [COLOR_BITS-1:0] wr_data;
  logic [INDEX_BITS-1:0] vid_idx;

  logic [COLOR_BITS-1:0] s1_r, s1_g, s1_b;
  logic                  s1_de;

  assign cpu_ch  = cpu_addr[INDEX_BITS+1:INDEX_BITS];
  assign cpu_idx = cpu_addr[INDEX_BITS-1:0];
  assign vid_idx = sel ? cb : ca;

  // A reset cycle must not commit a clear write, so an aborted clear stops exactly at the counter
  assign clr_we  = (state == CLEAR) && !reset;
  assign cpu_we  = cpu_wr && (state == IDLE) && !reset;
  assign wr_idx  = clr_we ? cnt : cpu_idx;
  assign wr_data = clr_we ? CLR_DATA : cpu_din;
  assign we_r    = clr_we || (cpu_we && (cpu_ch == CH_R));
  assign we_g    = clr_we || (cpu_we && (cpu_ch == CH_G));
  assign we_b    = clr_we || (cpu_we && (cpu_ch == CH_B));

  assign busy = busy_q;

  // Clear sequencer state register
  always_ff @(posedge dclk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy_q        <= 1'b0;
      start_pending <= CLEAR_ON_RESET;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      busy_q        <= (state_next == CLEAR);
      start_pending <= 1'b0;
    end
  end

  // Clear sequencer next-state: walk every index once, then return to idle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear_req || start_pending) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Table writes from the clear sequencer or the CPU port
  always_ff @(posedge dclk) begin
    if (we_r) mem_r[wr_idx] <= wr_data;
    if (we_g) mem_g[wr_idx] <= wr_data;
    if (we_b) mem_b[wr_idx] <= wr_data;
  end

  // CPU read port: old data on same-cycle write, unmapped channel reads zero
  always_ff @(posedge dclk) begin
    if (reset) begin
      cpu_dout     <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= cpu_rd;
      if (cpu_rd) begin
        case (cpu_ch)
          CH_R:    cpu_dout <= mem_r[cpu_idx];
          CH_G:    cpu_dout <= mem_g[cpu_idx];
          CH_B:    cpu_dout <= mem_b[cpu_idx];
          default: cpu_dout <= '0;
        endcase
      end
    end
  end

  // Video pipeline: table lookup, then blanking outside the active display
  always_ff @(posedge dclk) begin
    if (reset) begin
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
      s1_de  <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      de_out <= 1'b0;
    end else if (ce_pix) begin
      s1_r   <= mem_r[vid_idx];
      s1_g   <= mem_g[vid_idx];
      s1_b   <= mem_b[vid_idx];
      s1_de  <= de;
      r_out  <= s1_de ? s1_r : '0;
      g_out  <= s1_de ? s1_g : '0;
      b_out  <= s1_de ? s1_b : '0;
      de_out <= s1_de;
    end
  end

endmodule
